quant_arbiter: RTL and testbench



---
 rtl/quant_arbiter_if.sv | 32 +++
 rtl/quant_arbiter.sv | 159 +++++++++++++++
 tb/tb_quant_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_arbiter_if.sv
// quant_arbiter_if: request/result bundle between the MAC lanes, the shared requantizer and the
// activation buffer.
//   req_valid / req_data / req_ready : per-lane accumulator offer, one-hot grant back
//   out_valid / out_ready            : result handshake toward the buffer
//   out_data / out_lane / out_sat    : quantized value, source lane, clamp flag
// Modports: slave = requantizer side, master = lanes + downstream consumer side.
interface quant_arbiter_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 16
);
  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]      req_valid;
  logic [NUM_LANES*IN_W-1:0] req_data;
  logic [NUM_LANES-1:0]      req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          out_data;
  logic [LANE_W-1:0]         out_lane;
  logic                      out_sat;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_lane, out_sat
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_lane, out_sat
  );
endinterface

// File: rtl/quant_arbiter.sv
// quant_arbiter: round-robin shares one requantizer (arithmetic right shift by SHIFT, then
// saturation to OUT_W bits) among NUM_LANES MAC lanes. Two registered stages: S1 holds the
// granted accumulator, S2 holds the quantized result (out_valid is its valid bit).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : quant_arbiter_if.slave (lane requests in, quantized results out)
//   sat_count : count of accepted clamped results, sticks at 16'hFFFF
// Build option: define QUANT_ROUND_EN to add 2^(SHIFT-1) before the shift (round half up);
// undefined gives a plain floor shift.
module quant_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned SHIFT     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  quant_arbiter_if.slave        bus,
  output logic [15:0]           sat_count
);
  localparam int unsigned LANE_W = $clog2(NUM_LANES);
  localparam logic signed [IN_W:0] QMax = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] QMin = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef QUANT_ROUND_EN
  localparam logic signed [IN_W:0] RndTerm = (IN_W+1)'(1) <<< (SHIFT-1);
`endif

  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_acc_q, s1_acc_d;
  logic [LANE_W-1:0] s1_lane_q, s1_lane_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [LANE_W-1:0] out_lane_q, out_lane_d;
  logic              out_sat_q, out_sat_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]       sat_count_q, sat_count_d;

  logic              s2_adv, s1_load_ok, found, xfer;
  logic [LANE_W-1:0] grant_idx, scan_idx;
  logic [IN_W-1:0]   grant_data;
  logic signed [IN_W:0] q_ext, q_shr;
  logic [OUT_W-1:0]  q_data;
  logic              q_sat;

  assign s2_adv     = !out_valid_q || bus.out_ready;
  assign s1_load_ok = !s1_valid_q || s2_adv;
  // No grant while reset is held, even though the scan itself is combinational.
  assign xfer       = found && s1_load_ok && !rst;

  // First requesting lane at or after rr_ptr, wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      scan_idx = LANE_W'((32'(rr_ptr_q) + k) % NUM_LANES);
      if (!found && bus.req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (LANE_W'(i) == grant_idx) grant_data = bus.req_data[i*IN_W +: IN_W];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant_idx] = 1'b1;
  end

  // Range check on the full-width shifted value so out-of-range inputs cannot alias.
  always_comb begin
    q_ext = {s1_acc_q[IN_W-1], s1_acc_q};
`ifdef QUANT_ROUND_EN
    q_ext = q_ext + RndTerm;
`endif
    q_shr = q_ext >>> SHIFT;
    if (q_shr > QMax) begin
      q_data = {1'b0, {(OUT_W-1){1'b1}}};
      q_sat  = 1'b1;
    end else if (q_shr < QMin) begin
      q_data = {1'b1, {(OUT_W-1){1'b0}}};
      q_sat  = 1'b1;
    end else begin
      q_data = q_shr[OUT_W-1:0];
      q_sat  = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_acc_d    = s1_acc_q;
    s1_lane_d   = s1_lane_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_sat_d   = out_sat_q;
    rr_ptr_d    = rr_ptr_q;
    sat_count_d = sat_count_q;

    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_acc_d   = grant_data;
      s1_lane_d  = grant_idx;
      rr_ptr_d   = (grant_idx == LANE_W'(NUM_LANES-1)) ? '0 : grant_idx + 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = q_data;
        out_lane_d = s1_lane_q;
        out_sat_d  = q_sat;
      end
    end

    if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_acc_q    <= '0;
      s1_lane_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_sat_q   <= 1'b0;
      rr_ptr_q    <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_acc_q    <= s1_acc_d;
      s1_lane_q   <= s1_lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_sat_q   <= out_sat_d;
      rr_ptr_q    <= rr_ptr_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_count     = sat_count_q;
endmodule

// File: tb/tb_quant_arbiter.sv
// tb_quant_arbiter: directed and randomized checks of quant_arbiter against a queue-based
// reference model (in-flight list with ages, round-robin pointer, arithmetic quantizer).
// Honours QUANT_ROUND_EN the same way as the design.
module tb_quant_arbiter;
  localparam int NL = 4;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int SH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sat_count;

  quant_arbiter_if #(.NUM_LANES(NL), .IN_W(IW), .OUT_W(OW)) bus ();

  quant_arbiter #(.NUM_LANES(NL), .IN_W(IW), .OUT_W(OW), .SHIFT(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lane;
    int          age;
  } ent_t;

  ent_t          pipe[$];
  int            rr;
  int            sat_model;
  bit            lane_v[NL];
  logic [31:0]   lane_d[NL];
  bit            rdy;
  logic [NL-1:0] obs_rdy;
  int            n_tests;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Floor division by 2^SH on plain integers, then clamp to the OW-bit signed range.
  function automatic void quant(input logic [31:0] a, output logic [OW-1:0] d, output bit s);
    longint v, q, dv;
    v = longint'(signed'(a));
`ifdef QUANT_ROUND_EN
    v = v + (longint'(1) << (SH - 1));
`endif
    dv = longint'(1) << SH;
    q = v / dv;
    if ((v % dv) != 0 && v < 0) q = q - 1;
    if (q > 32767) begin
      d = 16'h7FFF;
      s = 1'b1;
    end else if (q < -32768) begin
      d = 16'h8000;
      s = 1'b1;
    end else begin
      d = q[OW-1:0];
      s = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return {{8{r[23]}}, r[23:0]};
      2:       return 32'h007F_FF00 + {22'd0, r[9:0]};
      default: return 32'hFF7F_FE00 + {22'd0, r[9:0]};
    endcase
  endfunction

  // Drive lane/ready state, check all outputs against the model, then advance one clock.
  task automatic tick();
    int            g;
    bit            vis, cons, can;
    logic [NL-1:0] exp_rdy;
    logic [OW-1:0] ed;
    bit            es;
    for (int i = 0; i < NL; i++) begin
      bus.req_valid[i]          = lane_v[i];
      bus.req_data[i*IW +: IW] = lane_d[i];
    end
    bus.out_ready = rdy;
    #1;
    vis  = (pipe.size() > 0) && (pipe[0].age >= 1);
    cons = vis && rdy;
    can  = (pipe.size() - (cons ? 1 : 0)) < 2;
    g = -1;
    for (int k = 0; k < NL; k++) begin
      if (g < 0 && lane_v[(rr + k) % NL]) g = (rr + k) % NL;
    end
    exp_rdy = '0;
    if (g >= 0 && can) exp_rdy[g] = 1'b1;
    obs_rdy = bus.req_ready;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(bus.out_valid), 32'(vis));
    if (vis) begin
      quant(pipe[0].data, ed, es);
      check_eq("out_data", 32'(bus.out_data), 32'(ed));
      check_eq("out_lane", 32'(bus.out_lane), 32'(pipe[0].lane));
      check_eq("out_sat", 32'(bus.out_sat), 32'(es));
    end
    check_eq("sat_count", 32'(sat_count), 32'(sat_model));
    @(posedge clk);
    if (cons) begin
      quant(pipe[0].data, ed, es);
      if (es && sat_model < 65535) sat_model++;
      void'(pipe.pop_front());
    end
    foreach (pipe[i]) pipe[i].age++;
    if (exp_rdy != '0) begin
      pipe.push_back('{data: lane_d[g], lane: g, age: 0});
      lane_v[g] = 1'b0;
      rr = (g + 1) % NL;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_out_data", 32'(bus.out_data), 0);
    check_eq("rst_out_lane", 32'(bus.out_lane), 0);
    check_eq("rst_out_sat", 32'(bus.out_sat), 0);
    check_eq("rst_sat_count", 32'(sat_count), 0);
    pipe.delete();
    rr        = 0;
    sat_model = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int l);
    repeat (20) if (lane_v[l]) tick();
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input int lane, input bit sat);
    int n;
    n = 0;
    #1;
    while (!bus.out_valid && n < 10) begin
      tick();
      #1;
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 1);
    check_eq({tag, "_data"}, 32'(bus.out_data), 32'(d));
    check_eq({tag, "_lane"}, 32'(bus.out_lane), 32'(lane));
    check_eq({tag, "_sat"}, 32'(bus.out_sat), 32'(sat));
  endtask

  task automatic refill();
    for (int i = 0; i < NL; i++) begin
      if (!lane_v[i]) begin
        lane_v[i] = 1'b1;
        lane_d[i] = rnd_data();
      end
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NL; i++) lane_v[i] = 1'b0;
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rr = 0;
    sat_model = 0;
    rdy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      lane_v[i] = 1'b0;
      lane_d[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic transfer and latency.
    rdy = 1'b1;
    lane_d[0] = 32'h0001_2345;
    lane_v[0] = 1'b1;
    send(0);
    expect_out("t1", 16'h0123, 0, 1'b0);

    // Floor vs round-half-up.
    lane_d[1] = 32'h0000_0180;
    lane_v[1] = 1'b1;
    send(1);
`ifdef QUANT_ROUND_EN
    expect_out("t2a", 16'h0002, 1, 1'b0);
`else
    expect_out("t2a", 16'h0001, 1, 1'b0);
`endif
    lane_d[1] = 32'hFFFF_FE80;
    lane_v[1] = 1'b1;
    send(1);
`ifdef QUANT_ROUND_EN
    expect_out("t2b", 16'hFFFF, 1, 1'b0);
`else
    expect_out("t2b", 16'hFFFE, 1, 1'b0);
`endif

    // Saturation boundaries.
    lane_d[0] = 32'h0080_0000;
    lane_v[0] = 1'b1;
    send(0);
    expect_out("sat_pos", 16'h7FFF, 0, 1'b1);
    lane_d[0] = 32'hFF7F_FF00;
    lane_v[0] = 1'b1;
    send(0);
    expect_out("sat_neg", 16'h8000, 0, 1'b1);
    lane_d[0] = 32'hFF80_0000;
    lane_v[0] = 1'b1;
    send(0);
    expect_out("min_exact", 16'h8000, 0, 1'b0);
    tick();
    check_eq("sat_count_2", 32'(sat_count), 2);

    // Round-robin with all lanes busy, one grant per cycle.
    do_reset();
    for (int i = 0; i < NL; i++) begin
      lane_d[i] = 32'h0001_0000 * (i + 1);
      lane_v[i] = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      refill();
      tick();
      check_eq("rr_seq", 32'(obs_rdy), 32'(1) << (k % NL));
    end

    // Backpressure: only two entries may be taken.
    clear_lanes();
    repeat (3) tick();
    rdy = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      refill();
      tick();
      if (obs_rdy != '0) n++;
    end
    check_eq("bp_xfers", 32'(n), 2);
    check_eq("bp_ready_low", 32'(obs_rdy), 0);
    rdy = 1'b1;
    repeat (6) tick();

    // Reset with two entries in flight.
    rdy = 1'b0;
    refill();
    repeat (2) tick();
    check_eq("pre_rst_valid", 32'(bus.out_valid), 1);
    clear_lanes();
    lane_v[0] = 1'b1;
    lane_d[0] = 32'h0000_1200;
    lane_v[2] = 1'b1;
    lane_d[2] = 32'h0000_3400;
    do_reset();
    tick();
    check_eq("post_rst_grant", 32'(obs_rdy), 32'h1);
    rdy = 1'b1;
    repeat (4) tick();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (!lane_v[i] && ($urandom_range(0, 1) == 1)) begin
          lane_v[i] = 1'b1;
          lane_d[i] = rnd_data();
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_lanes();
    rdy = 1'b1;
    repeat (6) tick();
    check_eq("drained", 32'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
